// File: rtl/vga_buffer_ctrl_pkg.sv
// Shared geometry defaults, linear-address width and controller state encoding
// for the VGA frame-buffer controller.
package vga_buffer_ctrl_pkg;
  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int PIXEL_W      = 12;
  localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int LIN_ADDR_W   = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } vga_state_e;
endpackage

// File: rtl/vga_addr_gen.sv
// Row/column to linear frame-buffer address, with an in-range flag for the
// configured image geometry.
module vga_addr_gen
  import vga_buffer_ctrl_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic [7:0]            row,
  input  logic [8:0]            col,
  output logic [LIN_ADDR_W-1:0] addr,
  output logic                  in_range
);
  always_comb begin
    addr     = LIN_ADDR_W'(row) * LIN_ADDR_W'(WIDTH) + LIN_ADDR_W'(col);
    in_range = (int'(row) < HEIGHT) && (int'(col) < WIDTH);
  end
endmodule

// File: rtl/vga_buffer_ctrl.sv
// Frame-buffer RAM arbiter: read-priority sharing between VGA scan-out and the
// accelerator fill stream. Define VGA_DOUBLE_BUFFER_EN for ping-pong banks.
module vga_buffer_ctrl #(
  parameter int IMAGE_WIDTH  = vga_buffer_ctrl_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = vga_buffer_ctrl_pkg::IMAGE_HEIGHT,
  parameter int PIXEL_W      = vga_buffer_ctrl_pkg::PIXEL_W,
  parameter int ADDR_W       = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [7:0]         wr_row,
  input  logic [8:0]         wr_col,
  input  logic [PIXEL_W-1:0] wr_pixel,
  input  logic               rd_req,
  input  logic [7:0]         rd_row,
  input  logic [8:0]         rd_col,
  output logic               rd_valid,
  output logic [PIXEL_W-1:0] rd_pixel,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [PIXEL_W-1:0] ram_wdata,
  input  logic [PIXEL_W-1:0] ram_rdata,
  output logic               frame_done,
  output logic               err_oob,
  output logic               err_abort
);
  import vga_buffer_ctrl_pkg::*;

  localparam logic [LIN_ADDR_W-1:0] LAST_IDX = LIN_ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  vga_state_e              state_q, state_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [LIN_ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [PIXEL_W-1:0]      hold_data_q, hold_data_d;
  logic [LIN_ADDR_W-1:0]   count_q, count_d;
  logic                    bank_q, bank_d;
  logic                    err_oob_q, err_oob_d, err_abort_q, err_abort_d;
  logic                    ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
  logic [PIXEL_W-1:0]      ram_wdata_q, ram_wdata_d;
  logic                    frame_done_q, frame_done_d;
  logic                    rd_s1_q, rd_s1_d, rd_s1_ok_q, rd_s1_ok_d;
  logic                    rd_vld_q, rd_vld_d, rd_ok_q, rd_ok_d;

  logic [LIN_ADDR_W-1:0]   wr_lin, rd_lin;
  logic                    wr_in, rd_in, issue, accept, rd_hit;
  logic                    wr_bank, rd_bank;

  vga_addr_gen #(.WIDTH(IMAGE_WIDTH), .HEIGHT(IMAGE_HEIGHT)) u_wr_addr (
    .row(wr_row), .col(wr_col), .addr(wr_lin), .in_range(wr_in)
  );
  vga_addr_gen #(.WIDTH(IMAGE_WIDTH), .HEIGHT(IMAGE_HEIGHT)) u_rd_addr (
    .row(rd_row), .col(rd_col), .addr(rd_lin), .in_range(rd_in)
  );

`ifdef VGA_DOUBLE_BUFFER_EN
  assign wr_bank = bank_q;
  assign rd_bank = ~bank_q;
`else
  assign wr_bank = bank_q;
  assign rd_bank = bank_q;
`endif

  always_comb begin
    issue    = hold_vld_q && !rd_req;
    wr_ready = (state_q == FILL) && (!hold_vld_q || issue);
    accept   = wr_valid && wr_ready;
    rd_hit   = rd_req && rd_in;

    state_d      = state_q;
    count_d      = count_q;
    bank_d       = bank_q;
    err_oob_d    = err_oob_q;
    err_abort_d  = err_abort_q;
    frame_done_d = 1'b0;
    hold_vld_d   = hold_vld_q && !issue;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;

    if (accept) begin
      if (wr_in) begin
        hold_vld_d  = 1'b1;
        hold_addr_d = wr_lin;
        hold_data_d = wr_pixel;
      end else begin
        err_oob_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (frame_start) begin
        state_d = FILL;
        count_d = '0;
      end
      FILL: if (frame_start) begin
        count_d     = '0;
        err_abort_d = 1'b1;
      end else if (issue) begin
        count_d = count_q + LIN_ADDR_W'(1);
        if (count_q == LAST_IDX) begin
          frame_done_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: if (frame_start) begin
        state_d = FILL;
        count_d = '0;
`ifdef VGA_DOUBLE_BUFFER_EN
        bank_d  = ~bank_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Reads always own the port; the hold register only drains on idle cycles.
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (rd_hit) begin
      ram_en_d               = 1'b1;
      ram_addr_d             = ADDR_W'(rd_lin);
      ram_addr_d[ADDR_W-1]   = rd_bank;
    end else if (issue) begin
      ram_en_d               = 1'b1;
      ram_we_d               = 1'b1;
      ram_addr_d             = ADDR_W'(hold_addr_q);
      ram_addr_d[ADDR_W-1]   = wr_bank;
      ram_wdata_d            = hold_data_q;
    end

    rd_s1_d    = rd_req;
    rd_s1_ok_d = rd_hit;
    rd_vld_d   = rd_s1_q;
    rd_ok_d    = rd_s1_ok_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_vld_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      count_q      <= '0;
      bank_q       <= 1'b0;
      err_oob_q    <= 1'b0;
      err_abort_q  <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      frame_done_q <= 1'b0;
      rd_s1_q      <= 1'b0;
      rd_s1_ok_q   <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_vld_q   <= hold_vld_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      count_q      <= count_d;
      bank_q       <= bank_d;
      err_oob_q    <= err_oob_d;
      err_abort_q  <= err_abort_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      frame_done_q <= frame_done_d;
      rd_s1_q      <= rd_s1_d;
      rd_s1_ok_q   <= rd_s1_ok_d;
      rd_vld_q     <= rd_vld_d;
      rd_ok_q      <= rd_ok_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign frame_done = frame_done_q;
  assign err_oob    = err_oob_q;
  assign err_abort  = err_abort_q;
  assign rd_valid   = rd_vld_q;
  assign rd_pixel   = rd_ok_q ? ram_rdata : '0;
endmodule

// File: tb/tb_vga_buffer_ctrl.sv
// Scoreboard bench for vga_buffer_ctrl on a reduced 40x30 geometry with a
// behavioural RAM; expected reads/writes come from a frame-image model.
module tb_vga_buffer_ctrl;
  localparam int W  = 40;
  localparam int H  = 30;
  localparam int PW = 12;
  localparam int AW = 18;
  localparam int FP = W * H;

  logic          clk = 1'b0;
  logic          rst_n, frame_start, wr_valid, wr_ready, rd_req, rd_valid;
  logic [7:0]    wr_row, rd_row;
  logic [8:0]    wr_col, rd_col;
  logic [PW-1:0] wr_pixel, rd_pixel, ram_wdata;
  logic [PW-1:0] ram_rdata = '0;
  logic          ram_en, ram_we, frame_done, err_oob, err_abort;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  vga_buffer_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_pixel(wr_pixel), .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rd_valid), .rd_pixel(rd_pixel), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .frame_done(frame_done), .err_oob(err_oob), .err_abort(err_abort)
  );

  logic [PW-1:0] mem [int];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : '0;
    end
  end

  typedef struct packed { int cyc; logic [AW-1:0] addr; logic [PW-1:0] pix; } rd_exp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [PW-1:0] data; logic done; } wr_exp_t;

  rd_exp_t       rd_q[$];
  rd_exp_t       rdc_q[$];
  wr_exp_t       wr_q[$];
  logic [PW-1:0] ref_img [int];
  int  cyc = 0, n_checks = 0, n_fail = 0, done_cnt = 0, wr_seen = 0;
  int  m_count = 0, m_state = 0;
  bit  m_bank = 1'b0, m_oob = 1'b0, m_abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not matching the model (cycle %0d)", name, cyc);
  endtask

  function automatic bit inr(input int r, input int c);
    return (r < H) && (c < W);
  endfunction

  function automatic int key(input bit b, input int r, input int c);
    return (int'(b) << 17) | (r * W + c);
  endfunction

  function automatic bit wbank();
`ifdef VGA_DOUBLE_BUFFER_EN
    return m_bank;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit dbank();
`ifdef VGA_DOUBLE_BUFFER_EN
    return ~m_bank;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input bit wv, input int wr, input int wc, input logic [PW-1:0] wp,
                       input bit rq, input int rr, input int rc, input bit fs, output bit acc);
    rd_exp_t e;
    wr_exp_t w;
    int      k;
    @(negedge clk);
    wr_valid = wv; wr_row = 8'(wr); wr_col = 9'(wc); wr_pixel = wp;
    rd_req = rq; rd_row = 8'(rr); rd_col = 9'(rc); frame_start = fs;
    #1;
    acc = wv && wr_ready;
    if (rq) begin
      k      = key(dbank(), rr, rc);
      e.addr = AW'(k);
      e.pix  = (inr(rr, rc) && ref_img.exists(k)) ? ref_img[k] : '0;
      e.cyc  = cyc + 2;
      rd_q.push_back(e);
      if (inr(rr, rc)) begin
        e.cyc = cyc + 1;
        rdc_q.push_back(e);
      end
    end
    if (acc) begin
      if (inr(wr, wc)) begin
        k          = key(wbank(), wr, wc);
        ref_img[k] = wp;
        m_count++;
        w.addr = AW'(k);
        w.data = wp;
        w.done = (m_count == FP);
        if (w.done) m_state = 2;
        wr_q.push_back(w);
      end else begin
        m_oob = 1'b1;
      end
    end
    if (fs) begin
      if (m_state == 1) m_abort = 1'b1;
`ifdef VGA_DOUBLE_BUFFER_EN
      if (m_state == 2) m_bank = ~m_bank;
`endif
      m_count = 0;
      m_state = 1;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive(0, 0, 0, '0, 0, 0, 0, 0, acc);
  endtask

  task automatic write_px(input int r, input int c, input logic [PW-1:0] p, input int rd_pct);
    bit acc;
    int n;
    n = 0;
    do begin
      drive(1, r, c, p, ($urandom % 100) < rd_pct, H - 1, $urandom_range(0, W + 1), 0, acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) fail_evt("wr_accept_timeout");
  endtask

  task automatic read_rand(input int n);
    bit acc;
    repeat (n) drive(0, 0, 0, '0, ($urandom % 4) != 0, $urandom_range(0, H),
                     $urandom_range(0, W + 1), 0, acc);
  endtask

  initial begin : monitor
    rd_exp_t e;
    wr_exp_t w;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        if (rd_q.size() == 0) fail_evt("rd_valid_unexpected");
        else begin
          e = rd_q.pop_front();
          chk("rd_latency", cyc, e.cyc);
          chk("rd_pixel", 32'(rd_pixel), 32'(e.pix));
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        void'(rd_q.pop_front());
        fail_evt("rd_valid_missing");
      end
      if (ram_en && !ram_we) begin
        if (rdc_q.size() == 0) fail_evt("ram_read_unexpected");
        else begin
          e = rdc_q.pop_front();
          chk("ram_rd_cycle", cyc, e.cyc);
          chk("ram_rd_addr", 32'(ram_addr), 32'(e.addr));
        end
      end else if (rdc_q.size() > 0 && rdc_q[0].cyc <= cyc) begin
        void'(rdc_q.pop_front());
        fail_evt("ram_read_missing");
      end
      if (ram_en && ram_we) begin
        wr_seen++;
        if (wr_q.size() == 0) fail_evt("ram_write_unexpected");
        else begin
          w = wr_q.pop_front();
          chk("ram_wr_addr", 32'(ram_addr), 32'(w.addr));
          chk("ram_wr_data", 32'(ram_wdata), 32'(w.data));
          chk("frame_done", 32'(frame_done), 32'(w.done));
        end
      end else if (frame_done) begin
        fail_evt("frame_done_without_write");
      end
      if (frame_done) done_cnt++;
    end
  end

  initial begin : stim
    bit            acc;
    int            acc_n, seen0;
    logic [PW-1:0] p;
    rst_n = 1'b0; frame_start = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    wr_row = '0; wr_col = '0; wr_pixel = '0; rd_row = '0; rd_col = '0;
    repeat (4) @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_pixel", 32'(rd_pixel), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_err_oob", 32'(err_oob), 0);
    chk("rst_err_abort", 32'(err_abort), 0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_wr_ready", 32'(wr_ready), 0);

    drive(0, 0, 0, '0, 0, 0, 0, 1, acc);
    idle(1);
    chk("fill_wr_ready", 32'(wr_ready), 1);

    for (int a = 0; a < FP; a++) begin
      p = (a == FP - 1) ? 12'hABC : PW'($urandom);
      write_px(a / W, a % W, p, 0);
    end
    idle(4);
    chk("done_wr_ready", 32'(wr_ready), 0);
    chk("done_count_f1", done_cnt, 1);
    chk("err_oob_f1", 32'(err_oob), 0);
    chk("err_abort_f1", 32'(err_abort), 0);

    drive(0, 0, 0, '0, 1, H - 1, W - 1, 0, acc);
    drive(0, 0, 0, '0, 1, H, 5, 0, acc);
    read_rand(40);
    idle(3);

    drive(0, 0, 0, '0, 0, 0, 0, 1, acc);
    idle(2);
    chk("restart_err_abort", 32'(err_abort), 0);
    chk("restart_wr_ready", 32'(wr_ready), 1);
    drive(0, 0, 0, '0, 1, H - 1, W - 1, 0, acc);

    for (int i = 0; i < 100; i++) begin
      if (i == 50) write_px(2, W, PW'($urandom), 30);
      write_px($urandom_range(0, H - 2), $urandom_range(0, W - 1), PW'($urandom), 30);
    end
    idle(3);
    chk("err_oob_set", 32'(err_oob), 32'(m_oob));
    chk("no_early_done", done_cnt, 1);

    acc_n = 0;
    seen0 = wr_seen;
    p = PW'($urandom);
    for (int i = 0; i < 10; i++) begin
      drive(1, 3, 4, p, 1, H - 1, $urandom_range(0, W - 1), 0, acc);
      acc_n += int'(acc);
    end
    chk("stall_accepts", acc_n, 1);
    drive(0, 0, 0, '0, 0, 0, 0, 0, acc);
    chk("stall_no_issue", wr_seen, seen0);
    idle(1);
    chk("stall_issue_next", wr_seen, seen0 + 1);

    drive(0, 0, 0, '0, 0, 0, 0, 1, acc);
    idle(2);
    chk("abort_flag", 32'(err_abort), 32'(m_abort));
    chk("abort_no_done", done_cnt, 1);

    for (int i = 0; i < FP; i++)
      write_px($urandom_range(0, H - 2), $urandom_range(0, W - 1), PW'($urandom), 30);
    idle(4);
    chk("done_count_f3", done_cnt, 2);
    chk("done3_wr_ready", 32'(wr_ready), 0);

    read_rand(30);
    idle(4);
    chk("rd_queue_empty", rd_q.size(), 0);
    chk("rdcmd_queue_empty", rdc_q.size(), 0);
    chk("wr_queue_empty", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_buffer_ctrl.md
# vga_buffer_ctrl

Controller and arbiter in front of the single-port VGA frame-buffer RAM (320×240, 12-bit RGB). It sequences one accelerator frame-fill per VGA frame and shares the RAM between the accelerator write stream and the VGA scan-out reads, with reads strictly prioritised. It converts row/column coordinates to linear addresses and reports frame completion.

## Interface
Parameters:
- IMAGE_WIDTH, 320, pixels per row
- IMAGE_HEIGHT, 240, rows per frame
- PIXEL_W, 12, pixel width
- ADDR_W, 18, RAM address width; bit 17 is the bank bit, bits 16:0 are the linear address

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at VGA vsync
- wr_valid  in  1  accelerator pixel valid
- wr_ready  out  1  controller can accept the pixel
- wr_row  in  8  pixel row
- wr_col  in  9  pixel column
- wr_pixel  in  PIXEL_W  pixel data
- rd_req  in  1  VGA pixel read request
- rd_row  in  8  read row
- rd_col  in  9  read column
- rd_valid  out  1  rd_pixel is valid
- rd_pixel  out  PIXEL_W  read data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  PIXEL_W  RAM write data
- ram_rdata  in  PIXEL_W  RAM read data; synchronous, valid the cycle after ram_en with ram_we=0
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is committed
- err_oob  out  1  sticky: an out-of-range write coordinate was dropped
- err_abort  out  1  sticky: frame_start arrived during FILL

## Operation
- Address = row*IMAGE_WIDTH + col, computed at 17 bits. A coordinate is out of range if row ≥ IMAGE_HEIGHT or col ≥ IMAGE_WIDTH.
- States:
  - IDLE (after reset): wr_ready=0. frame_start → FILL.
  - FILL: writes accepted. When the commit count reaches IMAGE_WIDTH*IMAGE_HEIGHT (76800): pulse frame_done, go to DONE.
  - DONE: wr_ready=0. frame_start → FILL.
  - Entering FILL clears the commit count.
  - frame_start while in FILL: count cleared, set err_abort, stay in FILL, no frame_done.
- One-entry write hold register. wr_ready = FILL && (hold empty || hold issuing this cycle).
- Accepted out-of-range write: dropped, err_oob set, not counted.
- Arbitration: rd_req wins every cycle. The hold register issues only in a cycle with rd_req=0. Each issued write increments the commit count.
- Read, out-of-range coordinates: no RAM access; rd_pixel=0, rd_valid still asserted on schedule.
- RAM command outputs (ram_en/we/addr/wdata) are registered.

## Timing
- Reset value of every output is 0. State=IDLE, hold empty, count=0, bank=0, error flags cleared.
- Read latency: rd_req sampled in cycle N → RAM command in N+1 → rd_valid=1 with rd_pixel=ram_rdata in N+2. Reads are fully pipelined; one read per cycle is sustained.
- Write: accepted in N, hold issues in the first cycle M ≥ N+1 with rd_req=0, RAM write is visible at M+1.
- frame_done is asserted in the cycle the last write command appears on the RAM port.
- Reset mid-operation: the pending hold write is discarded and any in-flight rd_valid is cancelled.

## Configuration
- VGA_DOUBLE_BUFFER_EN defined:
  - Writes use bank wr_bank; reads use bank ~wr_bank (ram_addr[17]).
  - frame_start taken from DONE toggles wr_bank, so the completed frame is displayed.
  - frame_start from IDLE or FILL does not toggle the bank.
- VGA_DOUBLE_BUFFER_EN not defined: ram_addr[17]=0 always, and reads and writes share one bank (tearing allowed).

## Structure
- Shared package/header holds IMAGE_WIDTH, IMAGE_HEIGHT, PIXEL_W, FRAME_PIXELS=76800 and the state encodings IDLE/FILL/DONE.
- One sub-module, vga_addr_gen: coordinate → 17-bit address plus range flag. It is instantiated twice, once for the read path and once for the write path.

## Test plan
- Reset, then frame_start, then 76800 in-range writes with no reads → frame_done pulses once, at the 76800th commit; state becomes DONE and wr_ready=0.
- rd_req held high for 10 cycles while wr_valid=1 → exactly one write is accepted and none is issued. After rd_req drops, the write appears on the RAM port in the next cycle.
- Write (row 239, col 319, 12'hABC), then read the same coordinates → ram_addr=76799; rd_pixel=12'hABC at N+2.
- Write with col=320 → err_oob=1, no RAM write, count unchanged. Read with row=240 → rd_valid at N+2 with rd_pixel=0.
- frame_start after 100 writes in FILL → err_abort=1, count restarts, and frame_done does not pulse until 76800 further commits.
- With VGA_DOUBLE_BUFFER_EN: complete frame 1 (bank 0), then frame_start → writes go to ram_addr[17]=1 and reads to ram_addr[17]=0. Without the macro, ram_addr[17]=0 throughout.
